// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and MDU scoreboard stalls, branch flushes.
// Optional HAZARD_PERF_EN adds 32-bit stall/flush cycle counters (stall_cyc, flush_cyc).
module hazard_ctrl #(
  parameter int AW       = 5,
  parameter int NUM_RS   = 2,
  parameter int MAX_PEND = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RS*AW-1:0] rs_d,
  input  logic [AW-1:0]        rd_d,
  input  logic                 regwrite_d,
  input  logic                 mdu_op_d,
  input  logic [NUM_RS*AW-1:0] rs_e,
  input  logic [AW-1:0]        rd_e,
  input  logic                 load_e,
  input  logic                 mdu_issue_e,
  input  logic                 pcsrc_e,
  input  logic [AW-1:0]        rd_m,
  input  logic                 regwrite_m,
  input  logic [AW-1:0]        rd_w,
  input  logic                 regwrite_w,
  input  logic                 mdu_done,
  input  logic [AW-1:0]        mdu_rd,
  output logic [NUM_RS*2-1:0]  fwd,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [3:0]           mdu_cnt
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_cyc,
  output logic [31:0]          flush_cyc
`endif
);

  localparam int NREG = 2 ** AW;
  localparam logic [3:0] MAX_CNT = 4'(MAX_PEND);

  // Bit 0 exists only to keep indexing simple; it is held at 0 (x0 is never pending).
  logic [NREG-1:0] pend, pend_nxt, set_vec, clr_vec;
  logic [3:0]      cnt;
  logic            done_ok;
  logic [NUM_RS*2-1:0] fwd_raw;
  logic [AW-1:0]   src_e, src_d;
  logic            luh, sbh, fh, hz;

  always_comb begin
    fwd_raw = '0;
    src_e   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      src_e = rs_e[i*AW +: AW];
      if (regwrite_m && src_e != '0 && src_e == rd_m)
        fwd_raw[2*i +: 2] = 2'b10;
      else if (regwrite_w && src_e != '0 && src_e == rd_w)
        fwd_raw[2*i +: 2] = 2'b01;
    end
  end

  always_comb begin
    luh   = 1'b0;
    sbh   = 1'b0;
    src_d = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      src_d = rs_d[i*AW +: AW];
      if (load_e && rd_e != '0 && src_d == rd_e) luh = 1'b1;
      if (src_d != '0 && pend[src_d])            sbh = 1'b1;
    end
    if (regwrite_d && rd_d != '0 && pend[rd_d]) sbh = 1'b1;
    fh = mdu_op_d && (cnt == MAX_CNT) && !mdu_done;
    hz = (luh || sbh || fh) && !pcsrc_e;
  end

  // Outputs are gated by rst_n so they read 0 for the whole reset interval.
  assign fwd     = rst_n ? fwd_raw : '0;
  assign stall_f = rst_n & hz;
  assign stall_d = rst_n & hz;
  assign flush_d = rst_n & pcsrc_e;
  assign flush_e = rst_n & (pcsrc_e | hz);
  assign mdu_cnt = cnt;

  // A completion with nothing outstanding (e.g. a stale one after reset) is dropped.
  assign done_ok = mdu_done && (cnt != 4'd0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (mdu_issue_e && rd_e != '0) set_vec[rd_e] = 1'b1;
    if (done_ok)                   clr_vec[mdu_rd] = 1'b1;
    pend_nxt    = (pend & ~clr_vec) | set_vec;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      cnt  <= 4'd0;
    end else begin
      pend <= pend_nxt;
      if (mdu_issue_e && !done_ok && cnt < MAX_CNT)
        cnt <= cnt + 4'd1;
      else if (done_ok && !mdu_issue_e)
        cnt <= cnt - 4'd1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc <= '0;
      flush_cyc <= '0;
    end else begin
      if (stall_d) stall_cyc <= stall_cyc + 32'd1;
      if (flush_e) flush_cyc <= flush_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (AW=5, NUM_RS=2, MAX_PEND=4): forwarding, load-use,
// scoreboard, full-MDU, same-edge issue/done and mid-operation reset scenarios.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int NUM_RS = 2;
  localparam int MAX_PEND = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_RS*AW-1:0] rs_d, rs_e;
  logic [AW-1:0]        rd_d, rd_e, rd_m, rd_w, mdu_rd;
  logic                 regwrite_d, mdu_op_d, load_e, mdu_issue_e, pcsrc_e;
  logic                 regwrite_m, regwrite_w, mdu_done;
  logic [NUM_RS*2-1:0]  fwd;
  logic                 stall_f, stall_d, flush_d, flush_e;
  logic [3:0]           mdu_cnt;
`ifdef HAZARD_PERF_EN
  logic [31:0]          stall_cyc, flush_cyc;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.AW(AW), .NUM_RS(NUM_RS), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rd_d(rd_d), .regwrite_d(regwrite_d), .mdu_op_d(mdu_op_d),
    .rs_e(rs_e), .rd_e(rd_e), .load_e(load_e), .mdu_issue_e(mdu_issue_e),
    .pcsrc_e(pcsrc_e), .rd_m(rd_m), .regwrite_m(regwrite_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .mdu_done(mdu_done), .mdu_rd(mdu_rd),
    .fwd(fwd), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .mdu_cnt(mdu_cnt)
`ifdef HAZARD_PERF_EN
    , .stall_cyc(stall_cyc), .flush_cyc(flush_cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs_d = '0; rs_e = '0; rd_d = '0; rd_e = '0; rd_m = '0; rd_w = '0; mdu_rd = '0;
    regwrite_d = 0; mdu_op_d = 0; load_e = 0; mdu_issue_e = 0; pcsrc_e = 0;
    regwrite_m = 0; regwrite_w = 0; mdu_done = 0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] r);
    mdu_issue_e = 1; rd_e = r;
    tick();
    mdu_issue_e = 0; rd_e = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    pcsrc_e = 1; load_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd7};
    regwrite_m = 1; rd_m = 5'd3; rs_e = {5'd3, 5'd3};
    #12;
    checks++; if (stall_d !== 1'b0 || stall_f !== 1'b0) begin errors++; $display("FAIL rst_stall got %b%b exp 00", stall_f, stall_d); end
    checks++; if (flush_d !== 1'b0 || flush_e !== 1'b0) begin errors++; $display("FAIL rst_flush got %b%b exp 00", flush_d, flush_e); end
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL rst_fwd got %b exp 0000", fwd); end
    checks++; if (mdu_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", mdu_cnt); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_fwd();
    rd_m = 5'd5; rd_w = 5'd5; regwrite_m = 1; regwrite_w = 1; rs_e = {5'd0, 5'd5};
    #1;
    checks++; if (fwd !== 4'b0010) begin errors++; $display("FAIL fwd_m_prio got %b exp 0010", fwd); end
    regwrite_m = 0; #1;
    checks++; if (fwd !== 4'b0001) begin errors++; $display("FAIL fwd_w got %b exp 0001", fwd); end
    rs_e = {5'd0, 5'd0}; #1;
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL fwd_zero_src got %b exp 0000", fwd); end
    regwrite_m = 1; rd_m = 5'd6; rs_e = {5'd6, 5'd5}; #1;
    checks++; if (fwd !== 4'b1001) begin errors++; $display("FAIL fwd_two_src got %b exp 1001", fwd); end
    rd_m = 5'd0; rd_w = 5'd0; rs_e = '0; #1;
    checks++; if (fwd !== 4'b0000) begin errors++; $display("FAIL fwd_x0_dest got %b exp 0000", fwd); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    load_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd2}; #1;
    checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1101) begin errors++; $display("FAIL lu_stall got %b exp 1101", {stall_f, stall_d, flush_d, flush_e}); end
    tick();
    load_e = 0; rd_e = 5'd0; #1;
    checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0000) begin errors++; $display("FAIL lu_release got %b exp 0000", {stall_f, stall_d, flush_d, flush_e}); end
    load_e = 1; rd_e = 5'd7; pcsrc_e = 1; #1;
    checks++; if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin errors++; $display("FAIL lu_branch got %b exp 0011", {stall_f, stall_d, flush_d, flush_e}); end
    pcsrc_e = 0; rd_e = 5'd0; rs_d = '0; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_x0 got %b exp 0", stall_d); end
    clear_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    issue(5'd9);
    rs_d = {5'd0, 5'd9}; #1;
    checks++; if (stall_d !== 1'b1 || flush_e !== 1'b1) begin errors++; $display("FAIL sb_stall got %b%b exp 11", stall_d, flush_e); end
    checks++; if (mdu_cnt !== 4'd1) begin errors++; $display("FAIL sb_cnt got %0d exp 1", mdu_cnt); end
    tick();
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL sb_hold got %b exp 1", stall_d); end
    mdu_done = 1; mdu_rd = 5'd9; #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL sb_done_cycle got %b exp 1", stall_d); end
    tick();
    mdu_done = 0; mdu_rd = '0; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp 0", stall_d); end
    checks++; if (mdu_cnt !== 4'd0) begin errors++; $display("FAIL sb_cnt0 got %0d exp 0", mdu_cnt); end
    rs_d = '0;
    issue(5'd12);
    regwrite_d = 1; rd_d = 5'd12; #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL sb_waw got %b exp 1", stall_d); end
    mdu_done = 1; mdu_rd = 5'd12;
    tick();
    mdu_done = 0; #1;
    checks++; if (stall_d !== 1'b0 || mdu_cnt !== 4'd0) begin errors++; $display("FAIL sb_waw_clr got %b/%0d exp 0/0", stall_d, mdu_cnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_same_edge();
    issue(5'd8);
    mdu_issue_e = 1; rd_e = 5'd3; mdu_done = 1; mdu_rd = 5'd3;
    tick();
    clear_inputs();
    rs_d = {5'd0, 5'd3}; #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL se_pend3 got %b exp 1", stall_d); end
    checks++; if (mdu_cnt !== 4'd1) begin errors++; $display("FAIL se_cnt got %0d exp 1", mdu_cnt); end
    mdu_done = 1; mdu_rd = 5'd8;
    tick();
    mdu_done = 0; #1;
    checks++; if (stall_d !== 1'b1 || mdu_cnt !== 4'd0) begin errors++; $display("FAIL se_keep3 got %b/%0d exp 1/0", stall_d, mdu_cnt); end
    rs_d = {5'd0, 5'd8}; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL se_clr8 got %b exp 0", stall_d); end
    clear_inputs();
    tick();
  endtask

  task automatic test_full();
    issue(5'd1); issue(5'd2); issue(5'd4); issue(5'd5);
    checks++; if (mdu_cnt !== 4'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", mdu_cnt); end
    mdu_op_d = 1; #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", stall_d); end
    mdu_op_d = 0;
    issue(5'd6);
    checks++; if (mdu_cnt !== 4'd4) begin errors++; $display("FAIL full_sat got %0d exp 4", mdu_cnt); end
    mdu_op_d = 1; mdu_done = 1; mdu_rd = 5'd1; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL full_release got %b exp 0", stall_d); end
    tick();
    mdu_done = 0; #1;
    checks++; if (mdu_cnt !== 4'd3 || stall_d !== 1'b0) begin errors++; $display("FAIL full_after got %0d/%b exp 3/0", mdu_cnt, stall_d); end
    clear_inputs();
    mdu_done = 1; mdu_rd = 5'd2;
    tick();
    mdu_done = 0; #1;
    checks++; if (mdu_cnt !== 4'd2) begin errors++; $display("FAIL full_cnt2 got %0d exp 2", mdu_cnt); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 0;
    pcsrc_e = 1; load_e = 1; rd_e = 5'd7; rs_d = {5'd7, 5'd4};
    regwrite_w = 1; rd_w = 5'd4; rs_e = {5'd0, 5'd4}; #1;
    checks++; if ({stall_f, stall_d, flush_d, flush_e, fwd} !== 8'h00) begin errors++; $display("FAIL rm_outs got %b exp 00000000", {stall_f, stall_d, flush_d, flush_e, fwd}); end
    checks++; if (mdu_cnt !== 4'd0) begin errors++; $display("FAIL rm_cnt got %0d exp 0", mdu_cnt); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    mdu_done = 1; mdu_rd = 5'd4;
    tick();
    mdu_done = 0; #1;
    checks++; if (mdu_cnt !== 4'd0) begin errors++; $display("FAIL rm_no_underflow got %0d exp 0", mdu_cnt); end
    rs_d = {5'd5, 5'd4}; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL rm_pend_clr got %b exp 0", stall_d); end
    rs_d = {5'd0, 5'd3}; #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL rm_pend3_clr got %b exp 0", stall_d); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_load_use();
    test_scoreboard();
    test_same_edge();
    test_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter NUM_RS, default 2, legal 1..3, meaning source operands per instruction.
REQ-003 SHALL have parameter MAX_PEND, default 4, legal 1..15, meaning maximum outstanding long-latency (MDU) operations.
REQ-004 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rs_d, input, NUM_RS*AW, decode-stage sources; source i occupies bits [i*AW +: AW].
REQ-007 SHALL have port rd_d, input, AW, decode-stage destination.
REQ-008 SHALL have port regwrite_d, input, 1, decode-stage instruction writes rd_d.
REQ-009 SHALL have port mdu_op_d, input, 1, decode-stage instruction is an MDU op.
REQ-010 SHALL have port rs_e, input, NUM_RS*AW, execute-stage sources, same packing as rs_d.
REQ-011 SHALL have port rd_e, input, AW, execute-stage destination.
REQ-012 SHALL have port load_e, input, 1, execute-stage instruction is a load.
REQ-013 SHALL have port mdu_issue_e, input, 1, MDU op leaves E this cycle.
REQ-014 SHALL have port pcsrc_e, input, 1, taken branch/jump resolved in E.
REQ-015 SHALL have ports rd_m (input, AW), regwrite_m (input, 1), rd_w (input, AW) and regwrite_w (input, 1), giving the M and W writers.
REQ-016 SHALL have ports mdu_done (input, 1) and mdu_rd (input, AW), signalling MDU completion and its destination.
REQ-017 SHALL have port fwd, output, NUM_RS*2, forward select per source; 00 regfile, 10 from M, 01 from W.
REQ-018 SHALL have ports stall_f, stall_d, flush_d and flush_e, each output, 1.
REQ-019 SHALL have port mdu_cnt, output, 4, number of outstanding MDU ops.

Function
REQ-020 SHALL compute fwd combinationally with no delays: M match has priority over W; a match requires regwrite set and source != 0.
REQ-021 SHALL hold pend[2**AW-1:1] scoreboard bits; on a clock edge with mdu_issue_e and rd_e != 0 it SHALL set pend[rd_e].
REQ-022 SHALL clear pend[mdu_rd] on a clock edge with mdu_done; if issue and done target the same register on one edge, the set SHALL win.
REQ-023 SHALL update mdu_cnt as +1 on issue, -1 on done, unchanged on both or neither.
REQ-024 SHALL NOT decrement mdu_cnt below 0 and SHALL NOT increment it above MAX_PEND.
REQ-025 SHALL raise load-use hazard luh = load_e & rd_e != 0 & any rs_d == rd_e.
REQ-026 SHALL raise scoreboard hazard sbh = any nonzero rs_d pending, or regwrite_d & rd_d != 0 & pend[rd_d] (WAW).
REQ-027 SHALL raise full hazard fh = mdu_op_d & mdu_cnt == MAX_PEND & ~mdu_done.
REQ-028 SHALL assert stall_f = stall_d = (luh | sbh | fh) & ~pcsrc_e.
REQ-029 SHALL assert flush_d = pcsrc_e and flush_e = pcsrc_e | stall_d.
REQ-030 SHALL give combinational hazard-to-output latency of 0 cycles; a scoreboard update is visible on the cycle after the edge.

Reset
REQ-031 SHALL, while rst_n is low, clear pend and mdu_cnt and force stall_f, stall_d, flush_d, flush_e and fwd to 0.
REQ-032 SHALL, after a reset taken mid-operation, ignore mdu_done while mdu_cnt == 0 (no underflow, no pend change).

Configuration
REQ-033 SHALL, with HAZARD_PERF_EN defined, add 32-bit outputs stall_cyc and flush_cyc, counting cycles with stall_d=1 and with flush_e=1 respectively; both reset to 0 and wrap at 2**32.
REQ-034 SHALL, without HAZARD_PERF_EN, have neither port nor counter logic.

Verification
REQ-035 SHALL cover: rd_m=rd_w=5, both regwrite set, rs_e[0]=5 -> fwd[1:0]=10; regwrite_m=0 -> 01; rs_e[0]=0 -> 00.
REQ-036 SHALL cover: load_e=1, rd_e=7, rs_d[1]=7 -> stall_f=stall_d=flush_e=1 for exactly that cycle; with pcsrc_e=1 also asserted -> stall=0, flush_d=flush_e=1.
REQ-037 SHALL cover: mdu_issue_e with rd_e=9, then rs_d[0]=9 held -> stall_d=1 until the cycle after mdu_done with mdu_rd=9, then 0.
REQ-038 SHALL cover: MAX_PEND=4, four issues with no done -> mdu_cnt=4, and mdu_op_d=1 -> stall_d=1; asserting mdu_done releases the stall in the same cycle.
REQ-039 SHALL cover: issue rd=3 and done rd=3 on the same edge -> pend[3]=1, mdu_cnt unchanged.
REQ-040 SHALL cover: rst_n low with mdu_cnt=2, then mdu_done after release -> mdu_cnt stays 0 and all outputs are 0 during reset.
